// File: rtl/mrv32_wb_arbiter_if.sv
// rtl/mrv32_wb_arbiter_if.sv - bus bundle between pipeline/load unit/decode and the write-back arbiter
interface mrv32_wb_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    logic                          wb_valid;
    logic [4:0]                    wb_rd_addr;
    logic [31:0]                   wb_rd_data;
    logic                          lu_valid;
    logic                          lu_ready;
    logic [4:0]                    lu_rd_addr;
    logic [31:0]                   lu_rd_data;
    logic [4:0]                    rs1_addr;
    logic [4:0]                    rs2_addr;
    logic                          rs1_busy;
    logic                          rs2_busy;
    logic                          stall_req;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          reg_wen;
    logic [4:0]                    rd_addr;
    logic [31:0]                   rd_data;

    modport master (
        output wb_valid, wb_rd_addr, wb_rd_data,
        output lu_valid, lu_rd_addr, lu_rd_data,
        output rs1_addr, rs2_addr,
        input  lu_ready, rs1_busy, rs2_busy, stall_req, fifo_count,
        input  reg_wen, rd_addr, rd_data
    );

    modport slave (
        input  wb_valid, wb_rd_addr, wb_rd_data,
        input  lu_valid, lu_rd_addr, lu_rd_data,
        input  rs1_addr, rs2_addr,
        output lu_ready, rs1_busy, rs2_busy, stall_req, fifo_count,
        output reg_wen, rd_addr, rd_data
    );
endinterface

// File: rtl/mrv32_wb_arbiter.sv
// rtl/mrv32_wb_arbiter.sv - register-file write port arbiter: WB stage first, buffered long-latency results drain in idle slots
module mrv32_wb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mrv32_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    // Secondary result buffer; entries may be invalidated in place by a younger primary write
    logic [4:0]             addr_q [FIFO_DEPTH];
    logic [31:0]            data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  vld_q, vld_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic [SW-1:0]          starve_q, starve_d;
    logic                   stall_q, stall_d;

    logic                   reg_wen_q, reg_wen_d;
    logic [4:0]             rd_addr_q, rd_addr_d;
    logic [31:0]            rd_data_q, rd_data_d;

    logic                   wb_win;
    logic                   fifo_empty;
    logic                   lu_ready;
    logic                   pop;
    logic                   push;
    logic                   rs1_hit;
    logic                   rs2_hit;

    // Slot arbitration: a primary write to x0 is dropped and leaves the slot free for draining
    always_comb begin
        wb_win     = bus.wb_valid && (bus.wb_rd_addr != 5'd0);
        fifo_empty = (count_q == '0);
        lu_ready   = (count_q < CW'(FIFO_DEPTH));
        pop        = !wb_win && !fifo_empty;
        // x0 results and results overwritten by a same-cycle primary write are accepted but not stored
        push       = bus.lu_valid && lu_ready && (bus.lu_rd_addr != 5'd0)
                     && !(wb_win && (bus.lu_rd_addr == bus.wb_rd_addr));
    end

    // Entry valid bits: primary write squashes older matching entries, pop retires head, push fills tail
    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wb_win && (addr_q[i] == bus.wb_rd_addr)) begin
                vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    // Pointer and occupancy update; slots are counted whether or not the entry is still valid
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next write-port value; address/data hold when no write happens
    always_comb begin
        reg_wen_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (wb_win) begin
            reg_wen_d = 1'b1;
            rd_addr_d = bus.wb_rd_addr;
            rd_data_d = bus.wb_rd_data;
        end else if (pop && vld_q[rd_ptr_q]) begin
            reg_wen_d = 1'b1;
            rd_addr_d = addr_q[rd_ptr_q];
            rd_data_d = data_q[rd_ptr_q];
        end
    end

    // Starvation tracking: count blocked cycles, reset on any drain or when nothing is waiting
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (wb_win && (starve_q != SW'(STARVE_LIM))) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == SW'(STARVE_LIM));
    end

    // Pending-write lookup for decode: live valid entries plus the write currently on the port
    always_comb begin
        rs1_hit = reg_wen_q && (rd_addr_q == bus.rs1_addr);
        rs2_hit = reg_wen_q && (rd_addr_q == bus.rs2_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == bus.rs1_addr)) begin
                rs1_hit = 1'b1;
            end
            if (vld_q[i] && (addr_q[i] == bus.rs2_addr)) begin
                rs2_hit = 1'b1;
            end
        end
    end

    // Buffer payload storage; contents are only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.lu_rd_addr;
            data_q[wr_ptr_q] <= bus.lu_rd_data;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            stall_q   <= 1'b0;
            reg_wen_q <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= 32'd0;
        end else begin
            vld_q     <= vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            reg_wen_q <= reg_wen_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.lu_ready   = lu_ready;
    assign bus.rs1_busy   = (bus.rs1_addr != 5'd0) && rs1_hit;
    assign bus.rs2_busy   = (bus.rs2_addr != 5'd0) && rs2_hit;
    assign bus.stall_req  = stall_q;
    assign bus.fifo_count = count_q;
    assign bus.reg_wen    = reg_wen_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_data    = rd_data_q;
endmodule
